register_file: RTL and testbench



---
 rtl/register_file_if.sv | 39 +++
 rtl/register_file.sv | 90 +++++++++
 tb/tb_register_file.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file bus: two read ports, write port, reserve port, scoreboard.
// Master drives addresses/writes/reserves; slave returns data and status.
interface register_file_if #(
  parameter int N         = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5
);
  logic [ADDR_W-1:0]    rd_addr0;
  logic [N-1:0]         rd_data0;
  logic                 rd_ready0;
  logic [ADDR_W-1:0]    rd_addr1;
  logic [N-1:0]         rd_data1;
  logic                 rd_ready1;
  logic                 wr_ena;
  logic [ADDR_W-1:0]    wr_addr;
  logic [N-1:0]         wr_data;
  logic                 rsv_ena;
  logic [ADDR_W-1:0]    rsv_addr;
  logic [REG_COUNT-1:0] pending;
  logic                 rsv_conflict;

  modport master (
    output rd_addr0, rd_addr1,
    output wr_ena, wr_addr, wr_data,
    output rsv_ena, rsv_addr,
    input  rd_data0, rd_ready0,
    input  rd_data1, rd_ready1,
    input  pending, rsv_conflict
  );

  modport slave (
    input  rd_addr0, rd_addr1,
    input  wr_ena, wr_addr, wr_data,
    input  rsv_ena, rsv_addr,
    output rd_data0, rd_ready0,
    output rd_data1, rd_ready1,
    output pending, rsv_conflict
  );
endinterface

// File: rtl/register_file.sv
// Integer register file with pending scoreboard; x0 reads as zero.
// Optional REGFILE_BYPASS_EN adds write-first forwarding on both read ports.
module register_file #(
  parameter int N         = 32,
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5
) (
  input logic             clk,
  input logic             rst,
  register_file_if.slave  bus
);

  logic [N-1:0]         r_regs [REG_COUNT];
  logic [REG_COUNT-1:0] r_pending;
  logic                 r_conflict;

  logic                 w_wr;
  logic                 w_rsv;
  logic                 w_conflict;
  logic [REG_COUNT-1:0] w_pending_nxt;

  assign w_wr  = bus.wr_ena  && (bus.wr_addr  != '0);
  assign w_rsv = bus.rsv_ena && (bus.rsv_addr != '0);

  // WAW: reserving a register whose producer is still outstanding,
  // unless this same edge's write retires that producer first.
  assign w_conflict = w_rsv && r_pending[bus.rsv_addr] &&
                      !(w_wr && (bus.wr_addr == bus.rsv_addr));

  // Next scoreboard: write clears, then reserve sets (new producer wins).
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wr)
      w_pending_nxt[bus.wr_addr] = 1'b0;
    if (w_rsv)
      w_pending_nxt[bus.rsv_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Register storage, scoreboard and conflict pulse update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++)
        r_regs[i] <= '0;
      r_pending  <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_wr)
        r_regs[bus.wr_addr] <= bus.wr_data;
      r_pending  <= w_pending_nxt;
      r_conflict <= w_conflict;
    end
  end

  // Read port 0: zero/ready for x0, else stored value and scoreboard.
  always_comb begin
    bus.rd_data0  = r_regs[bus.rd_addr0];
    bus.rd_ready0 = ~r_pending[bus.rd_addr0];
    if (bus.rd_addr0 == '0) begin
      bus.rd_data0  = '0;
      bus.rd_ready0 = 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
    else if (w_wr && (bus.rd_addr0 == bus.wr_addr)) begin
      bus.rd_data0  = bus.wr_data;
      bus.rd_ready0 = 1'b1;
    end
`endif
  end

  // Read port 1: same rules as port 0.
  always_comb begin
    bus.rd_data1  = r_regs[bus.rd_addr1];
    bus.rd_ready1 = ~r_pending[bus.rd_addr1];
    if (bus.rd_addr1 == '0) begin
      bus.rd_data1  = '0;
      bus.rd_ready1 = 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
    else if (w_wr && (bus.rd_addr1 == bus.wr_addr)) begin
      bus.rd_data1  = bus.wr_data;
      bus.rd_ready1 = 1'b1;
    end
`endif
  end

  assign bus.pending      = r_pending;
  assign bus.rsv_conflict = r_conflict;

endmodule

// File: tb/tb_register_file.sv
// Directed plus random test of register_file against an array-based model.
// Model expectations honour REGFILE_BYPASS_EN when defined.
module tb_register_file;

  logic clk;
  logic rst;

  register_file_if #(.N(32), .REG_COUNT(32), .ADDR_W(5)) bus ();

  register_file #(.N(32), .REG_COUNT(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mreg [32];
  logic [31:0] mpend;
  logic        mconf;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_ena && bus.wr_addr != 0 && bus.wr_addr == a)
      return bus.wr_data;
`endif
    return mreg[a];
  endfunction

  function automatic logic exp_ready(input logic [4:0] a);
    if (a == 0) return 1'b1;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_ena && bus.wr_addr != 0 && bus.wr_addr == a)
      return 1'b1;
`endif
    return !mpend[a];
  endfunction

  // Apply current inputs at the next edge, in model and DUT alike.
  task automatic tick();
    logic [31:0] np;
    logic        c;
    np = mpend;
    c  = 1'b0;
    if (rst) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
      np = 32'h0;
    end else begin
      c = bus.rsv_ena && bus.rsv_addr != 0 && mpend[bus.rsv_addr] &&
          !(bus.wr_ena && bus.wr_addr == bus.rsv_addr);
      if (bus.wr_ena && bus.wr_addr != 0) begin
        mreg[bus.wr_addr] = bus.wr_data;
        np[bus.wr_addr] = 1'b0;
      end
      if (bus.rsv_ena && bus.rsv_addr != 0)
        np[bus.rsv_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
    mpend = np;
    mconf = c;
  endtask

  task automatic idle();
    rst = 0;
    bus.wr_ena = 0;
    bus.rsv_ena = 0;
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".d0"}, 64'(bus.rd_data0), 64'(exp_data(bus.rd_addr0)));
    chk({tag, ".r0"}, 64'(bus.rd_ready0), 64'(exp_ready(bus.rd_addr0)));
    chk({tag, ".d1"}, 64'(bus.rd_data1), 64'(exp_data(bus.rd_addr1)));
    chk({tag, ".r1"}, 64'(bus.rd_ready1), 64'(exp_ready(bus.rd_addr1)));
    chk({tag, ".pend"}, 64'(bus.pending), 64'(mpend));
    chk({tag, ".conf"}, 64'(bus.rsv_conflict), 64'(mconf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] old4;
    for (int i = 0; i < 32; i++) mreg[i] = 32'hx;
    mpend = 32'hx;
    mconf = 1'bx;
    rst = 1;
    bus.rd_addr0 = 0;
    bus.rd_addr1 = 0;
    bus.wr_ena = 0;
    bus.wr_addr = 0;
    bus.wr_data = 0;
    bus.rsv_ena = 0;
    bus.rsv_addr = 0;
    tick();
    idle();

    // Random writes and reserves, then reset with colliding requests.
    for (int k = 0; k < 12; k++) begin
      bus.wr_ena = 1;
      bus.wr_addr = 5'($urandom_range(1, 31));
      bus.wr_data = $urandom;
      bus.rsv_ena = 1;
      bus.rsv_addr = 5'($urandom_range(1, 31));
      tick();
    end
    rst = 1;
    bus.wr_ena = 1;
    bus.wr_addr = 6;
    bus.rsv_ena = 1;
    bus.rsv_addr = 6;
    tick();
    idle();
    chk("rst.pend", 64'(bus.pending), 64'h0);
    chk("rst.conf", 64'(bus.rsv_conflict), 64'h0);
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr0 = 5'(i);
      bus.rd_addr1 = 5'(31 - i);
      #1;
      chk("rst.d0", 64'(bus.rd_data0), 64'h0);
      chk("rst.d1", 64'(bus.rd_data1), 64'h0);
      chk("rst.r0", 64'(bus.rd_ready0), 64'h1);
      chk("rst.r1", 64'(bus.rd_ready1), 64'h1);
    end

    // x0 drop and basic write.
    bus.wr_ena = 1;
    bus.wr_addr = 0;
    bus.wr_data = 32'hDEADBEEF;
    tick();
    bus.wr_addr = 5;
    bus.wr_data = 32'h12345678;
    tick();
    idle();
    bus.rd_addr0 = 0;
    bus.rd_addr1 = 5;
    #1;
    chk("x0", 64'(bus.rd_data0), 64'h0);
    chk("x5", 64'(bus.rd_data1), 64'h12345678);

    // Both ports on the same register.
    bus.wr_ena = 1;
    bus.wr_addr = 7;
    bus.wr_data = 32'hFFFFFFFF;
    tick();
    idle();
    bus.rd_addr0 = 7;
    bus.rd_addr1 = 7;
    #1;
    chk("dual.d0", 64'(bus.rd_data0), 64'hFFFFFFFF);
    chk("dual.d1", 64'(bus.rd_data1), 64'hFFFFFFFF);

    // Scoreboard set then cleared by writeback.
    bus.rsv_ena = 1;
    bus.rsv_addr = 3;
    tick();
    idle();
    bus.rd_addr0 = 3;
    #1;
    chk("rsv3.pend", 64'(bus.pending), 64'h8);
    chk("rsv3.r0", 64'(bus.rd_ready0), 64'h0);
    bus.wr_ena = 1;
    bus.wr_addr = 3;
    bus.wr_data = 32'h80000000;
    tick();
    idle();
    #1;
    chk("wb3.pend", 64'(bus.pending), 64'h0);
    chk("wb3.r0", 64'(bus.rd_ready0), 64'h1);
    chk("wb3.d0", 64'(bus.rd_data0), 64'h80000000);

    // Reserve of x0 is ignored.
    bus.rsv_ena = 1;
    bus.rsv_addr = 0;
    tick();
    tick();
    idle();
    #1;
    chk("rsv0.pend", 64'(bus.pending), 64'h0);
    chk("rsv0.conf", 64'(bus.rsv_conflict), 64'h0);

    // WAW conflict on x9.
    bus.rsv_ena = 1;
    bus.rsv_addr = 9;
    tick();
    #1;
    chk("waw1.conf", 64'(bus.rsv_conflict), 64'h0);
    tick();
    idle();
    #1;
    chk("waw2.conf", 64'(bus.rsv_conflict), 64'h1);
    chk("waw2.p9", 64'(bus.pending[9]), 64'h1);
    tick();
    #1;
    chk("waw3.conf", 64'(bus.rsv_conflict), 64'h0);

    // Same-cycle write and reserve of x9 while pending.
    bus.wr_ena = 1;
    bus.wr_addr = 9;
    bus.wr_data = 32'h1;
    bus.rsv_ena = 1;
    bus.rsv_addr = 9;
    tick();
    idle();
    bus.rd_addr1 = 9;
    #1;
    chk("wr_rsv.d1", 64'(bus.rd_data1), 64'h1);
    chk("wr_rsv.p9", 64'(bus.pending[9]), 64'h1);
    chk("wr_rsv.conf", 64'(bus.rsv_conflict), 64'h0);

    // Write-first forwarding (or not) on port 0.
    bus.wr_ena = 1;
    bus.wr_addr = 4;
    bus.wr_data = 32'h00000011;
    tick();
    idle();
    old4 = 32'h00000011;
    bus.rd_addr0 = 4;
    bus.wr_ena = 1;
    bus.wr_addr = 4;
    bus.wr_data = 32'h7FFFFFFF;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp.same", 64'(bus.rd_data0), 64'h7FFFFFFF);
`else
    chk("byp.same", 64'(bus.rd_data0), 64'(old4));
`endif
    tick();
    idle();
    #1;
    chk("byp.next", 64'(bus.rd_data0), 64'h7FFFFFFF);

    // Random traffic with operand sums through an ALU add model.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.wr_ena = 1'($urandom);
      bus.wr_addr = 5'($urandom_range(0, 15));
      bus.wr_data = $urandom;
      bus.rsv_ena = 1'($urandom);
      bus.rsv_addr = 5'($urandom_range(0, 15));
      bus.rd_addr0 = 5'($urandom_range(0, 15));
      bus.rd_addr1 = 5'($urandom_range(0, 15));
      check_all("rnd");
      chk("alu.add", 64'(bus.rd_data0 + bus.rd_data1),
          64'(exp_data(bus.rd_addr0) + exp_data(bus.rd_addr1)));
      tick();
    end
    idle();
    check_all("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
